// File: rtl/branch_target_buffer.sv
// branch_target_buffer -- direct-mapped branch target buffer with a saturating
// taken/not-taken counter per entry. After reset or flush, an INIT sweep
// invalidates one entry per cycle before lookups can hit and updates take effect.
// Optional feature: define BTB_BYPASS_EN so that a lookup and an update to the
// same index in the same cycle return the post-update entry. When it is
// undefined, that lookup returns the pre-update entry.
module branch_target_buffer #(
  parameter int ENTRIES = 64,
  parameter int PC_W    = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  output logic            ready,
  input  logic            lk_valid,
  input  logic [PC_W-1:0] lk_pc,
  output logic            lk_rvalid,
  output logic            lk_hit,
  output logic            lk_taken,
  output logic [PC_W-1:0] lk_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - 1 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX   = '1;
  // A freshly allocated entry starts one step above weakly-not-taken.
  localparam logic [CTR_W-1:0] ALLOC_CTR = CTR_W'(1 << (CTR_W - 1));
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRIES - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;

  // Entry storage. Only the valid bits need clearing, and the INIT sweep
  // does that; tag/target/counter are don't-care while invalid.
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [PC_W-1:0]    target_mem [ENTRIES];
  logic [CTR_W-1:0]   ctr_mem    [ENTRIES];

  // pc[0] is always zero for 2-byte instructions and is never used.
  logic unused_pc_lsb;
  assign unused_pc_lsb = &{1'b0, lk_pc[0], upd_pc[0]};

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  assign lk_idx  = lk_pc[IDX_W:1];
  assign lk_tag  = lk_pc[PC_W-1:IDX_W+1];
  assign upd_idx = upd_pc[IDX_W:1];
  assign upd_tag = upd_pc[PC_W-1:IDX_W+1];

  // State register for the INIT sweep and the RUN state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Next state. A flush always restarts the sweep from index 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d    = state_q;
    init_idx_d = init_idx_q;
    case (state_q)
      INIT: begin
        if (flush) begin
          init_idx_d = '0;
        end else if (init_idx_q == LAST_IDX) begin
          state_d    = RUN;
          init_idx_d = '0;
        end else begin
          init_idx_d = init_idx_q + IDX_W'(1);
        end
      end
      RUN: begin
        if (flush) begin
          state_d    = INIT;
          init_idx_d = '0;
        end
      end
      default: begin
        state_d    = INIT;
        init_idx_d = '0;
      end
    endcase
  end

  // Update path: the new contents of the addressed entry and its write enable.
  logic             upd_en, upd_hit, upd_we;
  logic [PC_W-1:0]  new_target;
  logic [CTR_W-1:0] new_ctr, old_ctr;

  always_comb begin
    old_ctr    = ctr_mem[upd_idx];
    upd_en     = upd_valid && (state_q == RUN) && !flush && !rst;
    upd_hit    = valid_q[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    new_target = upd_taken ? upd_target : target_mem[upd_idx];
    new_ctr    = ALLOC_CTR;
    if (upd_hit) begin
      if (upd_taken) new_ctr = (old_ctr == CTR_MAX) ? old_ctr : old_ctr + CTR_W'(1);
      else           new_ctr = (old_ctr == '0)      ? old_ctr : old_ctr - CTR_W'(1);
    end
    // A not-taken miss does not allocate.
    upd_we = upd_en && (upd_hit || upd_taken);
  end

  // Entry write: INIT clears one valid bit per cycle; RUN applies updates.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (state_q == INIT) begin
      valid_q[init_idx_q] <= 1'b0;
    end else if (upd_we) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload arrays are not reset; they are only written on an update.
  always_ff @(posedge clk) begin
    if (upd_we) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= new_target;
      ctr_mem[upd_idx]    <= new_ctr;
    end
  end

  // Lookup read, with an optional same-cycle forward from the update path.
  logic             rd_valid, lk_hit_d;
  logic [TAG_W-1:0] rd_tag;
  logic [PC_W-1:0]  rd_target;
  logic [CTR_W-1:0] rd_ctr;

  always_comb begin
    rd_valid  = valid_q[lk_idx];
    rd_tag    = tag_mem[lk_idx];
    rd_target = target_mem[lk_idx];
    rd_ctr    = ctr_mem[lk_idx];
`ifdef BTB_BYPASS_EN
    if (upd_we && (upd_idx == lk_idx)) begin
      rd_valid  = 1'b1;
      rd_tag    = upd_tag;
      rd_target = new_target;
      rd_ctr    = new_ctr;
    end
`endif
    lk_hit_d = (state_q == RUN) && rd_valid && (rd_tag == lk_tag);
  end

  // Lookup result registers; held while no lookup is issued.
  logic            lk_rvalid_q, lk_hit_q, lk_taken_q;
  logic [PC_W-1:0] lk_target_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_rvalid_q <= 1'b0;
      lk_hit_q    <= 1'b0;
      lk_taken_q  <= 1'b0;
      lk_target_q <= '0;
    end else begin
      lk_rvalid_q <= lk_valid;
      if (lk_valid) begin
        lk_hit_q    <= lk_hit_d;
        lk_taken_q  <= lk_hit_d && rd_ctr[CTR_W-1];
        lk_target_q <= lk_hit_d ? rd_target : '0;
      end
    end
  end

  // While rst is high, all outputs read as zero.
  assign ready     = (state_q == RUN) && !rst;
  assign lk_rvalid = lk_rvalid_q && !rst;
  assign lk_hit    = lk_hit_q && !rst;
  assign lk_taken  = lk_taken_q && !rst;
  assign lk_target = rst ? '0 : lk_target_q;

endmodule
